ulpb_member_rx: RTL and testbench
=================================

Name: ulpb_member_rx

Overview:
- Receive-side deframer for a ring member node.
- Sits directly downstream of the bus controller: CLKIN is the controller's gated bus clock, DIN is the ring data arriving from the previous hop.
- Tracks message phases (arbitration, priority, address, data, interrupt, control), captures 32-bit payload words addressed to this node into a small FIFO, and drives the ACK bit back onto the ring during CONTROL1.

Parameters:
- ADDRESS, 8'h05, this node's 8-bit bus address.
- BCAST_ADDR, 8'hFF, broadcast address; always accepted.
- FIFO_DEPTH, 2, payload word FIFO entries (power of 2, ≥2).

Ports:
- CLKIN  input  1  bus clock, posedge active; stops (held high) between messages and during interrupt.
- RESET  input  1  asynchronous reset, active high.
- DIN  input  1  ring data in, sampled at CLKIN posedge.
- INT_FLAG  input  1  level from the external interrupt detector, sampled at CLKIN posedge; held until after SWITCH.
- DOUT  output  1  ring data out to next hop.
- RX_DATA  output  32  FIFO head word.
- RX_VALID  output  1  FIFO non-empty.
- RX_READY  input  1  consumer pops the head when RX_VALID && RX_READY at posedge.
- RX_EOM  output  1  one-cycle pulse: addressed message completed.
- RX_ERR  output  1  one-cycle pulse, coincident with RX_EOM: overflow, partial word, or CONTROL0=0.

Behaviour:
- Reset: state=IDLE, FIFO empty, RX_VALID=0, RX_DATA=0, RX_EOM=0, RX_ERR=0, bit counter=0, shift register=0, overflow and addressed flags=0. DOUT follows DIN.
- States, with all transitions on CLKIN posedge:
  - IDLE: any posedge (arbitration edge) → PRIO.
  - PRIO: → ADDR, bit count cleared.
  - ADDR: shift DIN in MSB first. On the 8th bit, compare the full 8-bit address with ADDRESS or BCAST_ADDR. Match → DATA with addressed=1; no match → DROP.
  - DATA: shift DIN MSB first into a 32-bit register. On the 32nd bit, push the word (including the current bit) into the FIFO and reset the bit count to 0. If the FIFO is full, discard the word and set overflow.
  - DROP: ignore DIN.
  - INT_FLAG=1 in ADDR, DATA or DROP takes priority over shifting: → SWITCH, and DIN on that edge is discarded.
  - SWITCH: → CTRL0.
  - CTRL0: latch ctrl0=DIN → CTRL1.
  - CTRL1: → IDLE.
    - If addressed: RX_EOM=1 for one cycle; RX_ERR=1 if overflow OR (bit count≠0) OR ctrl0=0.
    - Clear the addressed, overflow and bit-count flags.
- INT_FLAG in IDLE, PRIO or SWITCH through CTRL1 is ignored.
- DOUT:
  - 0 while state==CTRL1, addressed=1 and no error (overflow=0, bit count=0, ctrl0=1). This is the ACK.
  - DIN in all other cases.
  - Decoded combinationally from registered state only.
- FIFO:
  - Push and pop in the same cycle are both honoured, and a full FIFO accepts the push in that case.
  - RX_DATA is valid whenever RX_VALID=1.
  - Popping an empty FIFO has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- RESET asserted mid-message: immediate return to IDLE and FIFO flushed. The next message is decoded from its arbitration edge.
- Latency: a word is visible on RX_VALID the cycle after its 32nd bit edge.

Test Plan:
- Addressed message: ADDR=0x05 followed by payload 0xDEADBEEF, then INT_FLAG, ctrl0=1 → RX_DATA=0xDEADBEEF with RX_VALID=1 one cycle after bit 32; DOUT=0 in CTRL1; RX_EOM=1, RX_ERR=0.
- Non-matching address 0x06 with two words → no FIFO push, DOUT==DIN throughout, no RX_EOM.
- Broadcast 0xFF followed by 0x00000001 and 0x80000000 → both words popped in order.
- RX_READY=0 with 3 words and FIFO_DEPTH=2 → first two words retained, third dropped; RX_ERR=1 at EOM; no ACK.
- Interrupt after 40 data bits → first word pushed; RX_ERR=1 for the partial word; DOUT=DIN in CTRL1.
- RESET pulsed during DATA bit 10 → FIFO empty, state IDLE; the following full message is decoded correctly.

Source files
------------

// File: rtl/ulpb_member_rx.sv
// ulpb_member_rx: receive-side deframer for a ring member node.
// Follows the message phases on the gated bus clock. It captures 32-bit
// payload words addressed to this node (or to broadcast) into a small FIFO.
// During CONTROL1 it pulls the ring low to acknowledge a clean message.
module ulpb_member_rx #(
    parameter logic [7:0] ADDRESS    = 8'h05,
    parameter logic [7:0] BCAST_ADDR = 8'hFF,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic        CLKIN,
    input  logic        RESET,
    input  logic        DIN,
    input  logic        INT_FLAG,
    output logic        DOUT,
    output logic [31:0] RX_DATA,
    output logic        RX_VALID,
    input  logic        RX_READY,
    output logic        RX_EOM,
    output logic        RX_ERR
);

    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIO   = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_DROP   = 3'd4,
        ST_SWITCH = 3'd5,
        ST_CTRL0  = 3'd6,
        ST_CTRL1  = 3'd7
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;

    logic [30:0]   shift_r;
    logic [4:0]    cnt_r;
    logic          addressed_r;
    logic          overflow_r;
    logic          ctrl0_r;
    logic          eom_r;
    logic          err_r;

    logic [31:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          shift_en_s;
    logic          cnt_clr_s;
    logic          cnt_inc_s;
    logic          set_addressed_s;
    logic          push_req_s;
    logic          ctrl0_ld_s;
    logic          msg_clr_s;
    logic          eom_s;
    logic          err_s;
    logic [7:0]    addr_word_s;
    logic [31:0]   data_word_s;
    logic          fifo_full_s;
    logic          pop_s;
    logic          push_ok_s;
    logic          msg_bad_s;

    // The bit just sampled completes the address byte or the data word.
    assign addr_word_s = {shift_r[6:0], DIN};
    assign data_word_s = {shift_r, DIN};

    assign fifo_full_s = (count_r == CW'(FIFO_DEPTH));
    assign pop_s       = (count_r != {CW{1'b0}}) && RX_READY;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign push_ok_s   = push_req_s && (!fifo_full_s || pop_s);
    assign msg_bad_s   = overflow_r || (cnt_r != 5'd0) || !ctrl0_r;

    assign RX_VALID = (count_r != {CW{1'b0}});
    assign RX_DATA  = mem_r[rd_ptr_r];
    assign RX_EOM   = eom_r;
    assign RX_ERR   = err_r;

    // ACK: drive the ring low in CONTROL1 for a clean addressed message.
    always_comb begin
        DOUT = DIN;
        if ((state_r == ST_CTRL1) && addressed_r && !msg_bad_s) begin
            DOUT = 1'b0;
        end else begin
            DOUT = DIN;
        end
    end

    // Phase state register.
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-phase decode and per-edge datapath controls.
    always_comb begin
        state_nxt_s     = state_r;
        shift_en_s      = 1'b0;
        cnt_clr_s       = 1'b0;
        cnt_inc_s       = 1'b0;
        set_addressed_s = 1'b0;
        push_req_s      = 1'b0;
        ctrl0_ld_s      = 1'b0;
        msg_clr_s       = 1'b0;
        eom_s           = 1'b0;
        err_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_PRIO;
            end
            ST_PRIO: begin
                state_nxt_s = ST_ADDR;
                cnt_clr_s   = 1'b1;
            end
            ST_ADDR: begin
                if (INT_FLAG) begin
                    state_nxt_s = ST_SWITCH;
                end else begin
                    shift_en_s = 1'b1;
                    if (cnt_r == 5'd7) begin
                        cnt_clr_s = 1'b1;
                        if ((addr_word_s == ADDRESS) || (addr_word_s == BCAST_ADDR)) begin
                            state_nxt_s     = ST_DATA;
                            set_addressed_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_DROP;
                        end
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (INT_FLAG) begin
                    state_nxt_s = ST_SWITCH;
                end else begin
                    shift_en_s = 1'b1;
                    if (cnt_r == 5'd31) begin
                        push_req_s = 1'b1;
                        cnt_clr_s  = 1'b1;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (INT_FLAG) begin
                    state_nxt_s = ST_SWITCH;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            ST_SWITCH: begin
                state_nxt_s = ST_CTRL0;
            end
            ST_CTRL0: begin
                state_nxt_s = ST_CTRL1;
                ctrl0_ld_s  = 1'b1;
            end
            ST_CTRL1: begin
                state_nxt_s = ST_IDLE;
                msg_clr_s   = 1'b1;
                eom_s       = addressed_r;
                err_s       = addressed_r && msg_bad_s;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Shift register, bit counter and per-message flags.
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            shift_r     <= 31'd0;
            cnt_r       <= 5'd0;
            addressed_r <= 1'b0;
            overflow_r  <= 1'b0;
            ctrl0_r     <= 1'b0;
            eom_r       <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            eom_r <= eom_s;
            err_r <= err_s;
            if (shift_en_s) begin
                shift_r <= data_word_s[30:0];
            end else begin
                shift_r <= shift_r;
            end
            if (cnt_clr_s || msg_clr_s) begin
                cnt_r <= 5'd0;
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + 5'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (msg_clr_s) begin
                addressed_r <= 1'b0;
            end else if (set_addressed_s) begin
                addressed_r <= 1'b1;
            end else begin
                addressed_r <= addressed_r;
            end
            if (msg_clr_s) begin
                overflow_r <= 1'b0;
            end else if (push_req_s && !push_ok_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            if (msg_clr_s) begin
                ctrl0_r <= 1'b0;
            end else if (ctrl0_ld_s) begin
                ctrl0_r <= DIN;
            end else begin
                ctrl0_r <= ctrl0_r;
            end
        end
    end

    // Payload FIFO: storage, pointers and occupancy count.
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= data_word_s;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (push_ok_s && !pop_s) begin
                count_r <= count_r + 1'b1;
            end else if (pop_s && !push_ok_s) begin
                count_r <= count_r - 1'b1;
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: tb/tb_ulpb_member_rx.sv
// Directed bench for ulpb_member_rx. The bus clock is gated, so every edge
// is produced on purpose by a task and each edge advances the message phase.
module tb_ulpb_member_rx;

    logic        CLKIN;
    logic        RESET;
    logic        DIN;
    logic        INT_FLAG;
    logic        DOUT;
    logic [31:0] RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        RX_EOM;
    logic        RX_ERR;

    int n_vec;
    int n_miss;

    ulpb_member_rx #(
        .ADDRESS    (8'h05),
        .BCAST_ADDR (8'hFF),
        .FIFO_DEPTH (2)
    ) dut (
        .CLKIN    (CLKIN),
        .RESET    (RESET),
        .DIN      (DIN),
        .INT_FLAG (INT_FLAG),
        .DOUT     (DOUT),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .RX_EOM   (RX_EOM),
        .RX_ERR   (RX_ERR)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus clock edge; outputs are settled 1 time unit after return.
    task automatic tick();
        #4 CLKIN = 1'b0;
        #5 CLKIN = 1'b1;
        #1;
    endtask

    task automatic send_bit(input logic b);
        DIN = b;
        tick();
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(w[31-i]);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_bits(w, 32);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic start_msg(input logic [7:0] addr);
        INT_FLAG = 1'b0;
        send_bit(1'b0);
        send_bit(1'b0);
        send_byte(addr);
    endtask

    // Interrupt, SWITCH, CONTROL0 and CONTROL1, with ACK and EOM checks.
    task automatic end_msg(input string tag, input logic ctrl0, input logic exp_ack,
                           input logic exp_eom, input logic exp_err);
        INT_FLAG = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(ctrl0);
        INT_FLAG = 1'b0;
        DIN = 1'b1;
        #1;
        check_eq({tag, "_dout_ctrl1"}, {31'd0, DOUT}, {31'd0, !exp_ack});
        tick();
        check_eq({tag, "_eom"}, {31'd0, RX_EOM}, {31'd0, exp_eom});
        check_eq({tag, "_err"}, {31'd0, RX_ERR}, {31'd0, exp_err});
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        CLKIN    = 1'b1;
        RESET    = 1'b1;
        DIN      = 1'b1;
        INT_FLAG = 1'b0;
        RX_READY = 1'b1;
        #3;
        check_eq("rst_valid", {31'd0, RX_VALID}, 32'd0);
        check_eq("rst_data", RX_DATA, 32'd0);
        check_eq("rst_eom", {31'd0, RX_EOM}, 32'd0);
        check_eq("rst_err", {31'd0, RX_ERR}, 32'd0);
        check_eq("rst_dout", {31'd0, DOUT}, 32'd1);
        RESET = 1'b0;
        #3;

        // 1: addressed single word with ACK
        start_msg(8'h05);
        send_bits(32'hDEADBEEF, 31);
        check_eq("t1_valid_before", {31'd0, RX_VALID}, 32'd0);
        send_bit(1'b1);
        check_eq("t1_valid", {31'd0, RX_VALID}, 32'd1);
        check_eq("t1_data", RX_DATA, 32'hDEADBEEF);
        end_msg("t1", 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t1_empty", {31'd0, RX_VALID}, 32'd0);

        // 2: foreign address, two words dropped
        start_msg(8'h06);
        DIN = 1'b1; #1;
        check_eq("t2_dout_hi", {31'd0, DOUT}, 32'd1);
        DIN = 1'b0; #1;
        check_eq("t2_dout_lo", {31'd0, DOUT}, 32'd0);
        send_word(32'h12345678);
        send_word(32'h9ABCDEF0);
        check_eq("t2_valid", {31'd0, RX_VALID}, 32'd0);
        end_msg("t2", 1'b1, 1'b0, 1'b0, 1'b0);

        // 3: broadcast, two words popped in order
        RX_READY = 1'b1;
        start_msg(8'hFF);
        send_word(32'h00000001);
        check_eq("t3_w0_valid", {31'd0, RX_VALID}, 32'd1);
        check_eq("t3_w0", RX_DATA, 32'h00000001);
        send_bit(1'b1);
        check_eq("t3_popped", {31'd0, RX_VALID}, 32'd0);
        send_bits(32'h00000000, 31);
        check_eq("t3_w1_valid", {31'd0, RX_VALID}, 32'd1);
        check_eq("t3_w1", RX_DATA, 32'h80000000);
        end_msg("t3", 1'b1, 1'b1, 1'b1, 1'b0);

        // 4: consumer stalled, three words into a two-entry FIFO
        RX_READY = 1'b0;
        start_msg(8'h05);
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        check_eq("t4_head", RX_DATA, 32'h11111111);
        end_msg("t4", 1'b1, 1'b0, 1'b1, 1'b1);

        // 5: drain t4 leftovers, then 40 data bits (one word plus partial)
        RX_READY = 1'b1;
        INT_FLAG = 1'b0;
        send_bit(1'b0);
        check_eq("t5_second", RX_DATA, 32'h22222222);
        send_bit(1'b0);
        check_eq("t5_drained", {31'd0, RX_VALID}, 32'd0);
        send_byte(8'h05);
        send_word(32'hCAFEF00D);
        check_eq("t5_word", RX_DATA, 32'hCAFEF00D);
        send_bits(32'hA5000000, 8);
        end_msg("t5", 1'b1, 1'b0, 1'b1, 1'b1);

        // 6: push and pop on the same edge while full
        RX_READY = 1'b0;
        start_msg(8'h05);
        send_word(32'hA1A1A1A1);
        send_word(32'hB2B2B2B2);
        send_bits(32'hC3C3C3C3, 31);
        RX_READY = 1'b1;
        send_bit(1'b1);
        RX_READY = 1'b0;
        check_eq("t6_head", RX_DATA, 32'hB2B2B2B2);
        end_msg("t6", 1'b1, 1'b1, 1'b1, 1'b0);

        // 7: drain t6, then addressed empty message with CONTROL0=0
        RX_READY = 1'b1;
        INT_FLAG = 1'b0;
        send_bit(1'b0);
        check_eq("t7_c_word", RX_DATA, 32'hC3C3C3C3);
        send_bit(1'b0);
        check_eq("t7_drained", {31'd0, RX_VALID}, 32'd0);
        send_byte(8'h05);
        end_msg("t7", 1'b0, 1'b0, 1'b1, 1'b1);

        // 8: reset during data bit 10, then a clean message
        RX_READY = 1'b0;
        start_msg(8'h05);
        send_word(32'h5A5A5A5A);
        check_eq("t8_pre_valid", {31'd0, RX_VALID}, 32'd1);
        send_bits(32'hFFC00000, 10);
        RESET = 1'b1;
        DIN   = 1'b1;
        #2;
        check_eq("t8_rst_valid", {31'd0, RX_VALID}, 32'd0);
        check_eq("t8_rst_data", RX_DATA, 32'd0);
        check_eq("t8_rst_dout", {31'd0, DOUT}, 32'd1);
        RESET = 1'b0;
        #2;
        start_msg(8'h05);
        send_word(32'h0BADF00D);
        check_eq("t8_valid", {31'd0, RX_VALID}, 32'd1);
        check_eq("t8_word", RX_DATA, 32'h0BADF00D);
        end_msg("t8", 1'b1, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
